// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver.
//
// Oversamples an asynchronous serial line with the system clock. The line is
// first brought into the clock domain by two flops. A falling edge starts a
// frame, and the start bit is confirmed at mid-bit. Eight data bits are then
// taken LSB first, and the stop bit is checked. Each frame ends in exactly one
// single-cycle pulse: valid_o for a good frame, frame_error_o for a low stop
// bit.
//
// Parameters:
//   CLOCKS_PER_BAUD  clock cycles per bit (>= 4); 104 gives 115200 baud at 12 MHz
//
// Ports:
//   clock_i        system clock
//   reset_n_i      synchronous, active-low reset
//   rx_i           asynchronous serial line, idle high
//   data_o         last good byte; holds until the next valid_o
//   valid_o        1-cycle pulse; data_o is valid this cycle
//   frame_error_o  1-cycle pulse; the stop bit was sampled low
//   busy_o         high whenever a frame is in progress or the line is held low
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each bit is the 2-of-3 majority of the
//                        synchronised line at counter values 2, 1 and 0. This
//                        rejects single-cycle spikes at the sample point. Ports
//                        and timing are the same in both builds.

module uart_rx #(
  parameter int CLOCKS_PER_BAUD = 104
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_error_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLOCKS_PER_BAUD / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic rx_p0;
  logic rx_p1;
`ifdef UART_RX_MAJORITY_EN
  logic rx_p2;
  logic rx_p3;
`endif

  logic sample_pt;
  logic bit_s;
  logic start_load;
  logic bit_load;
  logic shift_en;
  logic frame_ok;
  logic frame_bad;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Stage p0/p1: two-flop synchroniser. rx_p1 is the line used for every decision.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Stage p2/p3: the synchronised line as it was one and two cycles earlier.
  // Every sample point comes at least two cycles after a counter load, so
  // these hold the line values at counter == 1 and counter == 2.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      rx_p2 <= 1'b1;
      rx_p3 <= 1'b1;
    end else begin
      rx_p2 <= rx_p1;
      rx_p3 <= rx_p2;
    end
  end

  assign bit_s = majority3(rx_p1, rx_p2, rx_p3);
`else
  assign bit_s = rx_p1;
`endif

  assign sample_pt = (count == '0);

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_p1) state_next = START;
      START:     if (sample_pt) state_next = bit_s ? IDLE : DATA;
      DATA:      if (sample_pt && (bit_idx == 3'd7)) state_next = STOP;
      STOP:      if (sample_pt) state_next = bit_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_p1) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state != IDLE);
    start_load = (state == IDLE) && !rx_p1;
    // Reload a full bit time after a confirmed start bit and after every data
    // bit; the reload after bit 7 times the stop-bit sample.
    bit_load   = ((state == START) && sample_pt && !bit_s) ||
                 ((state == DATA) && sample_pt);
    shift_en   = (state == DATA) && sample_pt;
    frame_ok   = (state == STOP) && sample_pt && bit_s;
    frame_bad  = (state == STOP) && sample_pt && !bit_s;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      count         <= '0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      data_o        <= 8'h00;
      valid_o       <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      valid_o       <= frame_ok;
      frame_error_o <= frame_bad;

      if (start_load) begin
        count <= HALF_BIT;
      end else if (bit_load) begin
        count <= FULL_BIT;
      end else if (count != '0) begin
        count <= count - 1'b1;
      end

      if ((state == START) && sample_pt) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end

      // The line carries the LSB first, so each bit enters at the top and
      // moves right; after eight bits, the first bit received is in bit 0.
      if (shift_en) begin
        shift <= {bit_s, shift[7:1]};
      end

      if (frame_ok) begin
        data_o <= shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at 16 clocks per bit.
//
// A frame-level model follows the synchronised line and works out, cycle by
// cycle, what data_o, valid_o, frame_error_o and busy_o must be. Directed
// frames exercise normal bytes, back-to-back frames, a start glitch, a bad
// stop bit followed by a break, a mid-frame reset and a sample-point spike.
// Literal expectations per scenario pin the model.

module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clock_i   = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       rx_i      = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_error_o;
  logic       busy_o;

  uart_rx #(.CLOCKS_PER_BAUD(C)) dut (
    .clock_i      (clock_i),
    .reset_n_i    (reset_n_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .frame_error_o(frame_error_o),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: own copy of the synchroniser and the last three line values seen.
  logic       s0 = 1'b1;
  logic       s1 = 1'b1;
  logic       rs0 = 1'b1;
  logic       rs1 = 1'b1;
  logic       rs2 = 1'b1;
  logic       m_rst = 1'b0;
  logic       chk_en = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_fe = 1'b0;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_data = 8'h00;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         fe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic model_bit();
`ifdef UART_RX_MAJORITY_EN
    return (rs0 & rs1) | (rs0 & rs2) | (rs1 & rs2);
`else
    return rs0;
`endif
  endfunction

  // One clock edge of the model: rs0 is the synchronised line the receiver
  // acts on at this edge. Pulses default to low.
  task automatic tick();
    @(posedge clock_i);
    rs2 = rs1;
    rs1 = rs0;
    rs0 = s1;
    s1  = s0;
    s0  = rx_i;
    m_rst = !reset_n_i;
    exp_valid = 1'b0;
    exp_fe    = 1'b0;
    if (m_rst) begin
      s0 = 1'b1;
      s1 = 1'b1;
      exp_busy = 1'b0;
      exp_data = 8'h00;
    end
  endtask

  task automatic wait_sample(input int n, output logic b, output logic ab);
    ab = 1'b0;
    b  = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      if (m_rst) begin
        ab = 1'b1;
        return;
      end
    end
    b = model_bit();
  endtask

  task automatic receive_frame();
    logic       b;
    logic       ab;
    logic [7:0] sh;
    sh = 8'h00;
    wait_sample(H + 1, b, ab);
    if (ab) return;
    if (b) begin
      exp_busy = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      wait_sample(C, b, ab);
      if (ab) return;
      sh[i] = b;
    end
    wait_sample(C, b, ab);
    if (ab) return;
    if (b) begin
      exp_valid = 1'b1;
      exp_data  = sh;
      exp_busy  = 1'b0;
      return;
    end
    exp_fe = 1'b1;
    forever begin
      tick();
      if (m_rst) return;
      if (rs0) begin
        exp_busy = 1'b0;
        return;
      end
    end
  endtask

  initial begin : model
    forever begin
      tick();
      if (m_rst) begin
        chk_en = 1'b1;
      end else if (rs0 == 1'b0) begin
        exp_busy = 1'b1;
        receive_frame();
      end
    end
  end

  always @(negedge clock_i) begin
    cyc++;
    if (chk_en) begin
      check("valid_o", valid_o, exp_valid);
      check("frame_error_o", frame_error_o, exp_fe);
      check("busy_o", busy_o, exp_busy);
      check("data_o", data_o, exp_data);
      if (valid_o === 1'b1) begin
        got_q.push_back(data_o);
        got_cyc.push_back(cyc);
      end
      if (frame_error_o === 1'b1) fe_cnt++;
    end
  end

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    fe_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock_i);
      rx_i = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      @(negedge clock_i);
      rx_i = 1'b0;
    end
  endtask

  // Send one frame. glitch_pos inverts the single line cycle that the receiver
  // samples in that bit position (0 = start, 1..8 = data, 9 = stop).
  // rst_pos pulses reset for one cycle in that bit position, then drops the
  // rest of the frame with the line idle.
  task automatic send(input logic [7:0] b, input logic stop, input int glitch_pos,
                      input int rst_pos);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < C; k++) begin
        @(negedge clock_i);
        if (p == rst_pos && k == H) begin
          reset_n_i = 1'b0;
          rx_i      = 1'b1;
          @(negedge clock_i);
          reset_n_i = 1'b1;
          check("busy_after_reset", busy_o, 1'b0);
          return;
        end
        rx_i = fr[p] ^ ((p == glitch_pos) && (k == H + 1));
      end
    end
  endtask

  initial begin : stim
    reset_n_i = 1'b0;
    rx_i      = 1'b1;
    repeat (3) @(negedge clock_i);
    check("reset_data", data_o, 8'h00);
    check("reset_valid", valid_o, 1'b0);
    check("reset_fe", frame_error_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    reset_n_i = 1'b1;
    idle(20);

    // Single byte.
    clear_log();
    send(8'h41, 1'b1, -1, -1);
    idle(20);
    check("t1_pulses", got_q.size(), 1);
    check("t1_data", got_q[0], 8'h41);
    check("t1_fe", fe_cnt, 0);

    // Back-to-back frames with no idle gap.
    clear_log();
    send(8'h00, 1'b1, -1, -1);
    send(8'hFF, 1'b1, -1, -1);
    idle(20);
    check("t2_pulses", got_q.size(), 2);
    check("t2_data0", got_q[0], 8'h00);
    check("t2_data1", got_q[1], 8'hFF);
    check("t2_spacing", got_cyc[1] - got_cyc[0], 160);
    check("t2_fe", fe_cnt, 0);

    // Three-cycle start glitch.
    clear_log();
    hold_low(3);
    idle(30);
    check("t3_pulses", got_q.size(), 0);
    check("t3_fe", fe_cnt, 0);
    check("t3_busy", busy_o, 1'b0);

    // Bad stop bit, then a break, then a good frame.
    clear_log();
    send(8'h55, 1'b0, -1, -1);
    hold_low(100);
    check("t4_fe_once", fe_cnt, 1);
    check("t4_busy_in_break", busy_o, 1'b1);
    check("t4_data_held", data_o, 8'hFF);
    check("t4_no_valid", got_q.size(), 0);
    idle(20);
    check("t4_busy_after_break", busy_o, 1'b0);
    send(8'h5A, 1'b1, -1, -1);
    idle(20);
    check("t4_fe_total", fe_cnt, 1);
    check("t4_pulses", got_q.size(), 1);
    check("t4_data", got_q[0], 8'h5A);

    // Reset during data bit 3, then a fresh frame.
    clear_log();
    send(8'h77, 1'b1, -1, 4);
    idle(30);
    check("t5_no_pulse", got_q.size() + fe_cnt, 0);
    send(8'h33, 1'b1, -1, -1);
    idle(20);
    check("t5_pulses", got_q.size(), 1);
    check("t5_data", got_q[0], 8'h33);
    check("t5_fe", fe_cnt, 0);

    // One-cycle spike at the data bit 2 sample point.
    clear_log();
    send(8'hA5, 1'b1, 3, -1);
    idle(20);
    check("t6_pulses", got_q.size(), 1);
`ifdef UART_RX_MAJORITY_EN
    check("t6_data", got_q[0], 8'hA5);
`else
    check("t6_data", got_q[0], 8'hA1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
